// File: rtl/axis_wave_reader.sv
// axis_wave_reader: pulls a fixed-length burst of words from an upstream
// AXI-Stream FIFO and forwards them, one register stage later, to a DAC lane.
// A burst is armed with a length, started by a trigger, and can be cancelled
// at any time by abort. Cycles in playback with no word available are counted
// in a saturating underflow counter.
module axis_wave_reader #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 16
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              arm,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              trigger,
  input  logic              abort,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underflow_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [LEN_W-1:0]   remaining_d;
  logic [DATA_W-1:0]  dac_data_q;
  logic               dac_valid_q;
  logic [15:0]        underflow_q;
  logic [15:0]        underflow_d;
  logic               handshake;

  // Ready only while playing with words left; abort suppresses it so the
  // cancelling cycle never consumes a word. Never looks at tvalid.
  assign s_axis_tready = (state_q == PLAY) && (remaining_q != '0) && !abort;
  assign handshake     = s_axis_tready && s_axis_tvalid;

  // Next values for the down-counter and the saturating underflow counter.
  assign remaining_d = remaining_q - LEN_W'(1);
  assign underflow_d = (underflow_q == 16'hFFFF) ? underflow_q : underflow_q + 16'd1;

  assign dac_data      = dac_data_q;
  assign dac_valid     = dac_valid_q;
  assign underflow_cnt = underflow_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  // Burst control FSM together with the output data register and counters.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underflow_q <= '0;
    end else if (abort) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dac_valid_q <= 1'b0;
    end else begin
      dac_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm && (burst_len != '0)) begin
            state_q     <= ARMED;
            remaining_q <= burst_len;
            underflow_q <= '0;
          end
        end
        ARMED: begin
          if (trigger) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (handshake) begin
            dac_data_q  <= s_axis_tdata;
            dac_valid_q <= 1'b1;
            remaining_q <= remaining_d;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= DONE;
            end
          end else begin
            underflow_q <= underflow_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wave_reader.sv
// tb_axis_wave_reader: directed bursts through a modelled upstream FIFO.
// Expected DAC words go into a scoreboard queue when a burst is set up; a
// monitor pops and compares every time the DUT presents dac_valid.
module tb_axis_wave_reader;

  localparam int DATA_W = 256;
  localparam int LEN_W  = 16;

  logic              axis_clk;
  logic              rst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              arm;
  logic [LEN_W-1:0]  burst_len;
  logic              trigger;
  logic              abort;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              busy;
  logic              done;
  logic [15:0]       underflow_cnt;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] expQ[$];
  logic              tvalidEnable;
  logic              fire;
  int                consumedCnt = 0;
  int                validCnt    = 0;
  int                doneCnt     = 0;
  int                readyCnt    = 0;

  axis_wave_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .axis_clk      (axis_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .burst_len     (burst_len),
    .trigger       (trigger),
    .abort         (abort),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid),
    .busy          (busy),
    .done          (done),
    .underflow_cnt (underflow_cnt)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  // Full-width word pattern so truncated or shifted data paths show up.
  function automatic logic [DATA_W-1:0] makeWord(input int v);
    logic [31:0] w;
    w = 32'(v) ^ 32'h5A5A_0000;
    return {8{w}};
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkNum(input string name, input int actual, input int expected);
    checkOutput(name, DATA_W'(actual), DATA_W'(expected));
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // Drive one cycle of control pulses, starting just after a rising edge.
  task automatic applyStimulus(input logic a, input logic [LEN_W-1:0] len,
                               input logic t, input logic ab);
    arm       = a;
    burst_len = len;
    trigger   = t;
    abort     = ab;
    tick();
    arm     = 1'b0;
    trigger = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) tick();
    checkNum(name, int'(busy), 0);
  endtask

  // Upstream FIFO model: decide the handshake just before each rising edge,
  // then pop and present the next word shortly after it.
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    fire          = 1'b0;
    forever begin
      @(posedge axis_clk);
      #2;
      if (fire && fifoQ.size() > 0) begin
        void'(fifoQ.pop_front());
        consumedCnt++;
      end
      s_axis_tvalid = tvalidEnable && (fifoQ.size() > 0);
      s_axis_tdata  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
      #7;
      fire = s_axis_tvalid && s_axis_tready;
    end
  end

  // Monitor: scoreboard compare on every presented DAC word.
  initial begin
    logic [DATA_W-1:0] expWord;
    forever begin
      @(negedge axis_clk);
      if (s_axis_tready) readyCnt++;
      if (dac_valid) begin
        validCnt++;
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word (t=%0t)", dac_data, $time);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("dac_data", dac_data, expWord);
        end
      end
      if (done) begin
        doneCnt++;
        checkNum("done_with_valid", int'(dac_valid), 1);
        checkNum("done_last_word", expQ.size(), 0);
      end
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared + 1, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int baseConsumed, baseValid, baseDone, baseReady;

    rst          = 1'b1;
    arm          = 1'b0;
    trigger      = 1'b0;
    abort        = 1'b0;
    burst_len    = '0;
    tvalidEnable = 1'b1;

    #12;
    checkOutput("reset_dac_data", dac_data, '0);
    checkNum("reset_dac_valid", int'(dac_valid), 0);
    checkNum("reset_busy", int'(busy), 0);
    checkNum("reset_done", int'(done), 0);
    checkNum("reset_tready", int'(s_axis_tready), 0);
    checkNum("reset_underflow", int'(underflow_cnt), 0);
    #1;
    rst = 1'b0;
    tick();

    // arm with zero length and a stray trigger are both ignored
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
    checkNum("arm_len0_busy", int'(busy), 0);
    checkNum("arm_len0_tready", int'(s_axis_tready), 0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    checkNum("idle_trigger_busy", int'(busy), 0);
    checkNum("idle_trigger_tready", int'(s_axis_tready), 0);

    // four prefilled words played back to back
    for (int i = 1; i <= 4; i++) begin
      fifoQ.push_back(makeWord(i));
      expQ.push_back(makeWord(i));
    end
    baseConsumed = consumedCnt; baseValid = validCnt; baseDone = doneCnt; baseReady = readyCnt;
    applyStimulus(1'b1, 16'd4, 1'b0, 1'b0);
    checkNum("armed_busy", int'(busy), 1);
    tick();
    checkNum("armed_no_prefetch", int'(s_axis_tready), 0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    waitIdle(20, "burst4_finish");
    checkNum("burst4_ready_cycles", readyCnt - baseReady, 4);
    checkNum("burst4_valid_count", validCnt - baseValid, 4);
    checkNum("burst4_done_count", doneCnt - baseDone, 1);
    checkNum("burst4_consumed", consumedCnt - baseConsumed, 4);
    checkNum("burst4_underflow", int'(underflow_cnt), 0);

    // two empty cycles after trigger, then three words
    tvalidEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifoQ.push_back(makeWord(16'hA1 + i));
      expQ.push_back(makeWord(16'hA1 + i));
    end
    baseConsumed = consumedCnt; baseValid = validCnt; baseDone = doneCnt;
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    tick();
    tick();
    tvalidEnable = 1'b1;
    waitIdle(20, "burst3_finish");
    checkNum("burst3_underflow", int'(underflow_cnt), 2);
    checkNum("burst3_valid_count", validCnt - baseValid, 3);
    checkNum("burst3_done_count", doneCnt - baseDone, 1);
    checkNum("burst3_consumed", consumedCnt - baseConsumed, 3);

    // abort in the second playback cycle of an eight-word burst
    fifoQ.delete();
    for (int i = 0; i < 8; i++) fifoQ.push_back(makeWord(16'h20 + i));
    expQ.push_back(makeWord(16'h20));
    baseConsumed = consumedCnt; baseDone = doneCnt;
    applyStimulus(1'b1, 16'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    tick();
    abort = 1'b1;
    @(negedge axis_clk);
    checkNum("abort_tready", int'(s_axis_tready), 0);
    checkNum("abort_cycle_valid", int'(dac_valid), 1);
    tick();
    abort = 1'b0;
    checkNum("abort_busy", int'(busy), 0);
    checkNum("abort_dac_valid", int'(dac_valid), 0);
    tick();
    checkNum("abort_consumed", consumedCnt - baseConsumed, 1);
    checkNum("abort_no_done", doneCnt - baseDone, 0);

    // reset in the middle of a six-word burst, then replay two words
    fifoQ.delete();
    for (int i = 1; i <= 6; i++) fifoQ.push_back(makeWord(i));
    for (int i = 1; i <= 3; i++) expQ.push_back(makeWord(i));
    baseConsumed = consumedCnt; baseDone = doneCnt;
    applyStimulus(1'b1, 16'd6, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    @(negedge axis_clk);
    #1;
    rst = 1'b1;
    #1;
    checkNum("midreset_tready", int'(s_axis_tready), 0);
    checkNum("midreset_busy", int'(busy), 0);
    checkNum("midreset_dac_valid", int'(dac_valid), 0);
    checkOutput("midreset_dac_data", dac_data, '0);
    checkNum("midreset_done", int'(done), 0);
    tick();
    checkNum("midreset_consumed", consumedCnt - baseConsumed, 3);
    @(negedge axis_clk);
    #1;
    rst       = 1'b0;
    arm       = 1'b1;
    burst_len = 16'd2;
    tick();
    arm = 1'b0;
    checkNum("arm_after_reset", int'(busy), 1);
    expQ.push_back(makeWord(4));
    expQ.push_back(makeWord(5));
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    waitIdle(20, "replay_finish");
    checkNum("replay_consumed", consumedCnt - baseConsumed, 5);
    checkNum("replay_fifo_left", fifoQ.size(), 1);
    checkNum("replay_done_count", doneCnt - baseDone, 1);

    // arm and trigger together only arm; then abort back to idle
    fifoQ.delete();
    applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
    checkNum("arm_trig_busy", int'(busy), 1);
    tick();
    checkNum("arm_trig_not_playing", int'(s_axis_tready), 0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
    checkNum("armed_abort_busy", int'(busy), 0);

    // long starvation saturates the underflow counter
    tvalidEnable = 1'b0;
    fifoQ.push_back(makeWord(16'h55));
    expQ.push_back(makeWord(16'h55));
    baseDone = doneCnt;
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    repeat (70000) tick();
    checkNum("underflow_saturated", int'(underflow_cnt), 16'hFFFF);
    repeat (5) tick();
    checkNum("underflow_holds", int'(underflow_cnt), 16'hFFFF);
    checkNum("starved_tready", int'(s_axis_tready), 1);
    tvalidEnable = 1'b1;
    waitIdle(20, "starved_finish");
    checkNum("starved_underflow_after", int'(underflow_cnt), 16'hFFFF);
    checkNum("starved_done_count", doneCnt - baseDone, 1);

    tick();
    checkNum("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axis_wave_reader.md
AXIS_WAVE_READER -- requirements
Module: axis_wave_reader

Interface
REQ-001 Parameter DATA_W, default 256: AXI-Stream and DAC word width in bits.
REQ-002 Parameter LEN_W, default 16: width of burst length and remaining-word counter.
REQ-003 axis_clk  input  1  single clock for all logic; rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata  input  DATA_W  stream word from upstream FIFO master port.
REQ-006 s_axis_tvalid  input  1  upstream word available (FIFO not empty).
REQ-007 s_axis_tready  output  1  word consumed this cycle when tvalid&tready (FIFO read strobe).
REQ-008 arm  input  1  single-cycle request to load burst_len and arm.
REQ-009 burst_len  input  LEN_W  number of words to play; sampled only on accepted arm.
REQ-010 trigger  input  1  single-cycle playback start.
REQ-011 abort  input  1  synchronous cancel, highest priority after rst.
REQ-012 dac_data  output  DATA_W  registered sample word to DAC lane.
REQ-013 dac_valid  output  1  dac_data holds a new word this cycle.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 underflow_cnt  output  16  saturating count of PLAY cycles with no word available.

Function
REQ-017 States SHALL be IDLE, ARMED, PLAY, DONE; state register updates on rising axis_clk.
REQ-018 IDLE: arm=1 and burst_len!=0 -> ARMED, remaining<=burst_len, underflow_cnt<=0; arm with burst_len=0 ignored, no state change.
REQ-019 ARMED: trigger=1 -> PLAY next cycle; arm in ARMED ignored; s_axis_tready=0 (no prefetch).
REQ-020 PLAY: s_axis_tready SHALL be combinational (state==PLAY && remaining!=0), never dependent on s_axis_tvalid.
REQ-021 PLAY handshake cycle: dac_data<=s_axis_tdata, dac_valid<=1, remaining<=remaining-1; latency tdata->dac_data exactly 1 cycle.
REQ-022 PLAY non-handshake cycle: dac_valid<=0, dac_data holds, underflow_cnt<=underflow_cnt+1, saturating at 16'hFFFF.
REQ-023 Handshake consuming the last word (remaining==1) -> DONE next cycle; that word appears on dac_data with dac_valid=1 in the DONE cycle.
REQ-024 DONE: done=1 for exactly one cycle, s_axis_tready=0, then IDLE; arm in DONE ignored.
REQ-025 trigger outside ARMED SHALL be ignored; arm and trigger same cycle in IDLE -> ARMED only.
REQ-026 abort=1 in any state -> IDLE next cycle, dac_valid<=0, done not pulsed, remaining<=0; s_axis_tready SHALL be 0 in the abort cycle (no word consumed).
REQ-027 busy SHALL be combinational from state; done SHALL be combinational (state==DONE).
REQ-028 remaining SHALL never underflow; burst_len of 2^LEN_W-1 SHALL play that many words.
REQ-029 Words SHALL be forwarded unmodified and in order; no word dropped or duplicated.

Reset
REQ-030 On rst=1, immediately and without clock: state=IDLE, remaining=0, dac_data=0, dac_valid=0, underflow_cnt=0, s_axis_tready=0, busy=0, done=0.
REQ-031 rst asserted mid-PLAY SHALL drop s_axis_tready in the same cycle; no partial handshake counted; words left in the FIFO untouched.
REQ-032 First arm SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 FIFO prefilled with words 1..4, arm burst_len=4, trigger -> tready high 4 cycles, dac_data 1,2,3,4 with dac_valid on 4 consecutive cycles, done pulse coincident with word 4, underflow_cnt=0, busy low afterwards.
REQ-034 burst_len=3, tvalid low for 2 cycles after trigger then 3 words -> underflow_cnt=2, 3 dac_valid pulses, done once.
REQ-035 abort in 2nd PLAY cycle of burst_len=8 -> IDLE next cycle, exactly 1 word consumed from the FIFO, no done pulse, dac_valid=0.
REQ-036 arm with burst_len=0, and trigger while IDLE -> state stays IDLE, busy=0, tready=0 throughout.
REQ-037 rst asserted mid-PLAY (burst_len=6, 3 played) -> all outputs 0 asynchronously; new arm burst_len=2 plus trigger plays the next 2 FIFO words (4,5).
REQ-038 tvalid held low for 70000 PLAY cycles -> underflow_cnt saturates at 16'hFFFF and holds.
